mat_mult_seq: RTL and testbench

Sequenced 3x3 matrix multiplier controller. It accepts a pair of packed 3x3 operand matrices over a valid/ready handshake. It computes the product with one shared multiply-accumulate unit, one MAC per clock over 27 cycles. The result is presented on a valid/ready output port. It is the area-reduced, clocked counterpart of the combinational multiplier and sits between an operand producer and a result consumer.

---
 rtl/mat_mult_pkg.sv | 27 ++
 rtl/mat_mult_seq_mac.sv | 48 ++++
 rtl/mat_mult_seq.sv | 167 ++++++++++++++++
 tb/tb_mat_mult_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mult_pkg.sv
// -----------------------------------------------------------------------------
// mat_mult_pkg
// Shared definitions for the sequenced 3x3 matrix multiplier:
//   N              - matrix dimension (3)
//   ELEM_W_DEFAULT - default element width in bits
//   state_t        - controller states IDLE / COMPUTE / DONE
//   elem_offset()  - packed bit offset of element [row][col] in a row-major
//                    packed matrix whose element [0][0] sits in the MSBs
// -----------------------------------------------------------------------------
package mat_mult_pkg;

   localparam int N              = 3;
   localparam int ELEM_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Element [0][0] occupies the most significant slice, so the linear
   // row-major index is mirrored before scaling by the element width.
   function automatic int elem_offset(input int row, input int col, input int elem_w);
      return (N*N - 1 - (N*row + col)) * elem_w;
   endfunction

endpackage

// File: rtl/mat_mult_seq_mac.sv
// -----------------------------------------------------------------------------
// mat_mac
// Single multiply-accumulate step shared by every element of the product.
// Build option: MAT_MULT_SAT_EN selects a wide, non-wrapping accumulator with
// saturation at the element write; otherwise the sum wraps modulo 2^ELEM_W.
// Ports:
//   a, b      in   ELEM_W  unsigned operand elements A[i][k], B[k][j]
//   acc       in   ACC_W   running partial sum for the current element
//   acc_next  out  ACC_W   acc + a*b
//   elem      out  ELEM_W  acc + a*b reduced to the element width (wrapped
//                          or saturated), ready to be stored as the result
// -----------------------------------------------------------------------------
module mat_mac
   import mat_mult_pkg::*;
#(
   parameter int ELEM_W = ELEM_W_DEFAULT,
   parameter int ACC_W  = ELEM_W
) (
   input  logic [ELEM_W-1:0] a,
   input  logic [ELEM_W-1:0] b,
   input  logic [ACC_W-1:0]  acc,
   output logic [ACC_W-1:0]  acc_next,
   output logic [ELEM_W-1:0] elem
);

   logic [2*ELEM_W-1:0] product;

   assign product = (2*ELEM_W)'(a) * (2*ELEM_W)'(b);

`ifdef MAT_MULT_SAT_EN
   // The accumulator carries two guard bits beyond a full product so three
   // products can never wrap; anything above the element range clamps.
   logic [ACC_W-1:0] sum;

   assign sum      = ACC_W'(product) + acc;
   assign acc_next = sum;
   assign elem     = (|sum[ACC_W-1:ELEM_W]) ? '1 : sum[ELEM_W-1:0];
`else
   // Only the low ELEM_W bits survive, which equals summing at full width
   // and truncating once at the end.
   logic [2*ELEM_W-1:0] sum;

   assign sum      = product + (2*ELEM_W)'(acc);
   assign acc_next = sum[ACC_W-1:0];
   assign elem     = sum[ELEM_W-1:0];
`endif

endmodule

// File: rtl/mat_mult_seq.sv
// -----------------------------------------------------------------------------
// mat_mult_seq
// Sequenced 3x3 matrix multiplier: accepts an operand pair over a valid/ready
// handshake, computes A*B with one shared MAC (one step per clock, 27 steps)
// and presents the registered product on a valid/ready output.
// Build option: MAT_MULT_SAT_EN enables saturating element arithmetic.
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          operand pair offered
//   in_ready   out  1          high in IDLE
//   in_a       in   9*ELEM_W   matrix A, row-major, [0][0] in MSBs
//   in_b       in   9*ELEM_W   matrix B, same packing
//   out_valid  out  1          high in DONE
//   out_ready  in   1          consumer takes the result
//   out_res    out  9*ELEM_W   product A*B, same packing
//   busy       out  1          high in COMPUTE and DONE
// -----------------------------------------------------------------------------
module mat_mult_seq
   import mat_mult_pkg::*;
#(
   parameter int ELEM_W = ELEM_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*N*ELEM_W-1:0] in_a,
   input  logic [N*N*ELEM_W-1:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N*N*ELEM_W-1:0] out_res,
   output logic                  busy
);

`ifdef MAT_MULT_SAT_EN
   localparam int ACC_W = 2*ELEM_W + 2;
`else
   localparam int ACC_W = ELEM_W;
`endif
   localparam int         MAT_W = N*N*ELEM_W;
   localparam logic [1:0] LAST  = 2'(N-1);

   state_t            state;
   state_t            next_state;
   logic [1:0]        i;
   logic [1:0]        j;
   logic [1:0]        k;
   logic [MAT_W-1:0]  op_a;
   logic [MAT_W-1:0]  op_b;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next;
   logic [ELEM_W-1:0] mac_elem;
   logic [ELEM_W-1:0] a_m   [N][N];
   logic [ELEM_W-1:0] b_m   [N][N];
   logic [ELEM_W-1:0] res_m [N][N];
   logic              last_step;

   // Unpack the captured operands and pack the result register once, so the
   // datapath can address elements by (row, col) instead of bit offsets.
   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         assign a_m[r][c] = op_a[elem_offset(r, c, ELEM_W) +: ELEM_W];
         assign b_m[r][c] = op_b[elem_offset(r, c, ELEM_W) +: ELEM_W];
         assign out_res[elem_offset(r, c, ELEM_W) +: ELEM_W] = res_m[r][c];
      end
   end

   assign last_step = (i == LAST) && (j == LAST) && (k == LAST);

   mat_mac #(
      .ELEM_W (ELEM_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .a        (a_m[i][k]),
      .b        (b_m[k][j]),
      .acc      (acc),
      .acc_next (acc_next),
      .elem     (mac_elem)
   );

   // State register; reset aborts any computation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake outputs. Both handshakes are tied to distinct
   // states, so an input accept and an output release never coincide.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               next_state = COMPUTE;
            end
         end
         COMPUTE: begin
            busy = 1'b1;
            if (last_step) begin
               next_state = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath: capture operands on the accepting edge, then walk k fastest,
   // j, then i slowest. The k==2 step stores the finished element and clears
   // the accumulator for the next one, so the counters end back at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a <= '0;
         op_b <= '0;
         acc  <= '0;
         i    <= '0;
         j    <= '0;
         k    <= '0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               res_m[r][c] <= '0;
            end
         end
      end else if (state == IDLE) begin
         if (in_valid) begin
            op_a <= in_a;
            op_b <= in_b;
            acc  <= '0;
            i    <= '0;
            j    <= '0;
            k    <= '0;
         end
      end else if (state == COMPUTE) begin
         if (k == LAST) begin
            res_m[i][j] <= mac_elem;
            acc         <= '0;
            k           <= '0;
            if (j == LAST) begin
               j <= '0;
               i <= (i == LAST) ? 2'd0 : i + 2'd1;
            end else begin
               j <= j + 2'd1;
            end
         end else begin
            acc <= acc_next;
            k   <= k + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_mat_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_mat_mult_seq
// Self-checking bench for mat_mult_seq (ELEM_W = 8). Fixed and random operand
// pairs run through a table; hand-written sequences cover backpressure, reset
// during COMPUTE and back-to-back operation. Honours MAT_MULT_SAT_EN.
// -----------------------------------------------------------------------------
module tb_mat_mult_seq;

   localparam int EW      = 8;
   localparam int MW      = 9*EW;
   localparam int LATENCY = 27;
   localparam int NVEC    = 12;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b0;
   logic [MW-1:0] in_a      = '0;
   logic [MW-1:0] in_b      = '0;
   logic          in_ready;
   logic          out_valid;
   logic          busy;
   logic [MW-1:0] out_res;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      string         name;
      logic [MW-1:0] a;
      logic [MW-1:0] b;
      logic [MW-1:0] exp;
   } vec_t;

   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   mat_mult_seq #(.ELEM_W(EW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .busy      (busy)
   );

   // Reference product: full-precision dot products, reduced once at the end.
   function automatic logic [MW-1:0] refMul(input logic [MW-1:0] a, input logic [MW-1:0] b);
      logic [MW-1:0] r;
      int            s;
      r = '0;
      for (int row = 0; row < 3; row++) begin
         for (int col = 0; col < 3; col++) begin
            s = 0;
            for (int t = 0; t < 3; t++) begin
               s += int'(a[(8-(3*row+t))*EW +: EW]) * int'(b[(8-(3*t+col))*EW +: EW]);
            end
`ifdef MAT_MULT_SAT_EN
            if (s > 255) s = 255;
`else
            s = s % 256;
`endif
            r[(8-(3*row+col))*EW +: EW] = 8'(s);
         end
      end
      return r;
   endfunction

   function automatic logic [MW-1:0] randMat();
      logic [MW-1:0] m;
      for (int e = 0; e < 9; e++) begin
         m[e*EW +: EW] = 8'($urandom);
      end
      return m;
   endfunction

   task automatic checkVal(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Offer an operand pair, wait for acceptance, then count edges until out_valid.
   task automatic applyStimulus(input logic [MW-1:0] a, input logic [MW-1:0] b, output int lat);
      int waited;
      waited = 0;
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checkVal("accept_ready", MW'(in_ready), MW'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
      end
   endtask

   // Compare result and latency, then complete the output handshake.
   task automatic checkOutput(input string name, input logic [MW-1:0] exp, input int lat);
      @(negedge clk);
      checkVal({name, "_res"}, out_res, exp);
      checkVal({name, "_lat"}, MW'(lat), MW'(LATENCY));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   logic [MW-1:0] bp_a, bp_b, bp2_a, bp2_b, b2b_a [2], b2b_b [2], b2b_res [2];
   int            acc_t [2];
   int            n_acc, n_res, cyc;
   logic          will_accept;

   initial begin
      int lat;

      vecs[0] = '{"identity", 72'h010000000100000001, 72'h010203040506070809, 72'h010203040506070809};
      vecs[1] = '{"all_ones", 72'h010101010101010101, 72'h010101010101010101, 72'h030303030303030303};
`ifdef MAT_MULT_SAT_EN
      vecs[2] = '{"overflow", 72'h101010101010101010, 72'h101010101010101010, 72'hFFFFFFFFFFFFFFFFFF};
`else
      vecs[2] = '{"overflow", 72'h101010101010101010, 72'h101010101010101010, 72'h000000000000000000};
`endif
      vecs[3] = '{"twos_threes", 72'h020202020202020202, 72'h030303030303030303, 72'h121212121212121212};
      for (int v = 4; v < NVEC; v++) begin
         vecs[v].name = $sformatf("random%0d", v);
         vecs[v].a    = randMat();
         vecs[v].b    = randMat();
         vecs[v].exp  = refMul(vecs[v].a, vecs[v].b);
      end

      // Reset state
      @(negedge clk);
      checkVal("rst_in_ready", MW'(in_ready), MW'(1));
      checkVal("rst_out_valid", MW'(out_valid), MW'(0));
      checkVal("rst_busy", MW'(busy), MW'(0));
      checkVal("rst_out_res", out_res, '0);
      rst_n = 1'b1;

      // Table of operand pairs
      for (int v = 0; v < NVEC; v++) begin
         applyStimulus(vecs[v].a, vecs[v].b, lat);
         checkOutput(vecs[v].name, vecs[v].exp, lat);
      end

      // Backpressure: result held while a new pair waits on in_valid
      bp_a  = randMat();
      bp_b  = randMat();
      bp2_a = randMat();
      bp2_b = randMat();
      applyStimulus(bp_a, bp_b, lat);
      checkVal("bp_lat", MW'(lat), MW'(LATENCY));
      in_a     = bp2_a;
      in_b     = bp2_b;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkVal($sformatf("bp_hold_res%0d", c), out_res, refMul(bp_a, bp_b));
         checkVal($sformatf("bp_hold_in_ready%0d", c), MW'(in_ready), MW'(0));
         checkVal($sformatf("bp_hold_valid%0d", c), MW'(out_valid), MW'(1));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkVal("bp_ready_after", MW'(in_ready), MW'(1));
      applyStimulus(bp2_a, bp2_b, lat);
      checkOutput("bp_held_pair", refMul(bp2_a, bp2_b), lat);

      // Reset during the 10th COMPUTE cycle
      @(negedge clk);
      in_a     = 72'h020202020202020202;
      in_b     = 72'h030303030303030303;
      in_valid = 1'b1;
      checkVal("mr_ready", MW'(in_ready), MW'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("mr_out_valid", MW'(out_valid), MW'(0));
      checkVal("mr_busy", MW'(busy), MW'(0));
      checkVal("mr_out_res", out_res, '0);
      checkVal("mr_in_ready", MW'(in_ready), MW'(1));
      @(negedge clk);
      rst_n = 1'b1;
      bp_a = randMat();
      bp_b = randMat();
      applyStimulus(bp_a, bp_b, lat);
      checkOutput("mr_after", refMul(bp_a, bp_b), lat);

      // Back-to-back with out_ready tied high
      for (int p = 0; p < 2; p++) begin
         b2b_a[p]   = randMat();
         b2b_b[p]   = randMat();
         b2b_res[p] = '0;
         acc_t[p]   = 0;
      end
      n_acc = 0;
      n_res = 0;
      cyc   = 0;
      @(negedge clk);
      out_ready = 1'b1;
      in_a      = b2b_a[0];
      in_b      = b2b_b[0];
      in_valid  = 1'b1;
      while (n_res < 2 && cyc < 200) begin
         will_accept = in_ready && in_valid;
         if (out_valid) begin
            b2b_res[n_res] = out_res;
            n_res++;
         end
         @(posedge clk);
         cyc++;
         #1;
         if (will_accept && n_acc < 2) begin
            acc_t[n_acc] = cyc;
            n_acc++;
            if (n_acc == 1) begin
               in_a = b2b_a[1];
               in_b = b2b_b[1];
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkVal("b2b_res0", b2b_res[0], refMul(b2b_a[0], b2b_b[0]));
      checkVal("b2b_res1", b2b_res[1], refMul(b2b_a[1], b2b_b[1]));
      checkVal("b2b_gap", MW'(acc_t[1] - acc_t[0]), MW'(29));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
